bcd_up_counter_2digit: RTL

//   Two-digit BCD up counter, 00 -> MAX_COUNT, with a built-in tick prescaler.

---
 rtl/bcd_up_counter_2digit.sv | 81 ++++++++
 1 files changed

// File: rtl/bcd_up_counter_2digit.sv
// bcd_up_counter_2digit: two-digit BCD up counter 00..MAX_COUNT with tick prescaler and cascade carry
//   clki      - system clock, rising edge
//   reset     - asynchronous reset, active-low
//   enable    - count enable; low freezes prescaler and count
//   clear     - synchronous clear to 00 (highest priority)
//   load      - synchronous load of load_val (digits >9 become 0, values >MAX_COUNT become 00)
//   load_val  - {tens, ones} BCD load value
//   q_ones    - ones digit
//   q_tens    - tens digit
//   tc        - registered, high while the count equals MAX_COUNT
//   carry_out - registered one-cycle pulse in the cycle after the MAX->00 wrap
//   Define HOLD_AT_MAX_EN to saturate at MAX_COUNT instead of wrapping.
module bcd_up_counter_2digit #(
   parameter int MAX_COUNT = 99,
   parameter int DIV       = 1
) (
   input  logic       clki,
   input  logic       reset,
   input  logic       enable,
   input  logic       clear,
   input  logic       load,
   input  logic [7:0] load_val,
   output logic [3:0] q_ones,
   output logic [3:0] q_tens,
   output logic       tc,
   output logic       carry_out
);
   localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
   localparam logic [3:0] MAX_T = 4'(MAX_COUNT / 10);
   localparam logic [3:0] MAX_O = 4'(MAX_COUNT % 10);
`ifdef HOLD_AT_MAX_EN
   localparam bit HOLD = 1'b1;
`else
   localparam bit HOLD = 1'b0;
`endif
   logic [PW-1:0] psc, psc_nxt;
   logic [3:0] ld_o, ld_t, nxt_o, nxt_t;
   logic psc_last, step, at_max, ld_over, wrap;
   // With DIV=1 the prescaler is a dummy bit that stays 0 and every enabled edge steps.
   assign psc_last = (DIV == 1) || (psc == PW'(DIV - 1));
   assign step     = enable && psc_last;
   assign psc_nxt  = (clear || load) ? '0 : !enable ? psc : psc_last ? '0 : psc + 1'b1;
   assign at_max   = (q_tens == MAX_T) && (q_ones == MAX_O);
   assign ld_o     = load_val[3:0] > 4'd9 ? 4'd0 : load_val[3:0];
   assign ld_t     = load_val[7:4] > 4'd9 ? 4'd0 : load_val[7:4];
   assign ld_over  = (ld_t > MAX_T) || ((ld_t == MAX_T) && (ld_o > MAX_O));
   assign wrap     = !clear && !load && step && at_max && !HOLD;
   always_comb begin
      nxt_o = q_ones;
      nxt_t = q_tens;
      if (clear) begin
         nxt_o = 4'd0;
         nxt_t = 4'd0;
      end else if (load) begin
         nxt_o = ld_over ? 4'd0 : ld_o;
         nxt_t = ld_over ? 4'd0 : ld_t;
      end else if (step && at_max) begin
         nxt_o = HOLD ? q_ones : 4'd0;
         nxt_t = HOLD ? q_tens : 4'd0;
      end else if (step) begin
         nxt_o = q_ones == 4'd9 ? 4'd0 : q_ones + 4'd1;
         nxt_t = q_ones == 4'd9 ? q_tens + 4'd1 : q_tens;
      end
   end
   // tc is registered from the next-state value so it lines up with the outputs.
   always_ff @(posedge clki or negedge reset) begin
      if (!reset) begin
         psc       <= '0;
         q_ones    <= 4'd0;
         q_tens    <= 4'd0;
         tc        <= 1'b0;
         carry_out <= 1'b0;
      end else begin
         psc       <= psc_nxt;
         q_ones    <= nxt_o;
         q_tens    <= nxt_t;
         tc        <= (nxt_t == MAX_T) && (nxt_o == MAX_O);
         carry_out <= wrap;
      end
   end
endmodule
